vga_timing_ctrl: RTL

- Sequences the 640x480@60 Hz VGA raster from the 50 MHz board clock.
- Divides the board clock internally into a pixel-rate clock enable (pix_tick); no derived clock is used.
- Steps the horizontal and vertical position counters through active, front-porch, sync and back-porch phases.
- Drives hsync, vsync, video_on and the pixel coordinates to the downstream pixel generator.

---
 rtl/vga_timing_if.sv | 25 ++
 rtl/vga_timing_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_if.sv
// Raster timing bundle from vga_timing_ctrl to the downstream pixel generator.
// frame_cnt exists only when VGA_FRAME_CNT_EN is defined.
interface vga_timing_if;
   logic       pix_tick;
   logic       hsync;
   logic       vsync;
   logic       video_on;
   logic [9:0] pixel_x;
   logic [9:0] pixel_y;
   logic       line_start;
   logic       frame_start;
`ifdef VGA_FRAME_CNT_EN
   logic [15:0] frame_cnt;

   modport master (output pix_tick, hsync, vsync, video_on, pixel_x, pixel_y,
                   line_start, frame_start, frame_cnt);
   modport slave  (input  pix_tick, hsync, vsync, video_on, pixel_x, pixel_y,
                   line_start, frame_start, frame_cnt);
`else
   modport master (output pix_tick, hsync, vsync, video_on, pixel_x, pixel_y,
                   line_start, frame_start);
   modport slave  (input  pix_tick, hsync, vsync, video_on, pixel_x, pixel_y,
                   line_start, frame_start);
`endif
endinterface

// File: rtl/vga_timing_ctrl.sv
// VGA raster sequencer: pixel-rate enable from the board clock, h/v counters and sync phases.
// Optional frame counter on VGA_FRAME_CNT_EN.
module vga_timing_ctrl #(
   parameter int   CLK_DIV  = 2,
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic HS_POL   = 1'b0,
   parameter logic VS_POL   = 1'b0
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          en,
   vga_timing_if.master  vga
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_B_FP   = 10'(H_ACTIVE);
   localparam logic [9:0] H_B_SYNC = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] H_B_BP   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] V_B_FP   = 10'(V_ACTIVE);
   localparam logic [9:0] V_B_SYNC = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] V_B_BP   = 10'(V_ACTIVE + V_FP + V_SYNC);

   if (H_TOTAL > 1024) begin : g_h_total_chk
      $error("vga_timing_ctrl: H_TOTAL exceeds 1024");
   end
   if (V_TOTAL > 1024) begin : g_v_total_chk
      $error("vga_timing_ctrl: V_TOTAL exceeds 1024");
   end

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;
   typedef enum logic [1:0] {PH_ACT = 2'd0, PH_FP = 2'd1, PH_SYNC = 2'd2, PH_BP = 2'd3} phase_e;

   state_e           state_r, state_nxt_s;
   phase_e           h_phase_r, h_phase_nxt_s, v_phase_r, v_phase_nxt_s;
   logic [DIV_W-1:0] div_cnt_r, div_nxt_s;
   logic [9:0]       pixel_x_r, pixel_y_r, h_nxt_s, v_nxt_s;
   logic             hsync_r, vsync_r, video_on_r, pix_tick_r, line_start_r, frame_start_r;
   logic             hsync_nxt_s, vsync_nxt_s, video_on_nxt_s;
   logic             pix_tick_nxt_s, line_start_nxt_s, frame_start_nxt_s;
   logic             tick_s;

   // Phase changes only on the boundary positions; elsewhere the current phase holds.
   function automatic phase_e phase_step(input phase_e cur, input logic [9:0] pos,
                                         input logic [9:0] b_fp, input logic [9:0] b_sync,
                                         input logic [9:0] b_bp);
      phase_e res;
      if (pos == 10'd0)        res = PH_ACT;
      else if (pos == b_fp)    res = PH_FP;
      else if (pos == b_sync)  res = PH_SYNC;
      else if (pos == b_bp)    res = PH_BP;
      else                     res = cur;
      return res;
   endfunction

   assign tick_s    = en && (div_cnt_r == DIV_LAST);
   assign div_nxt_s = !en ? div_cnt_r : ((div_cnt_r == DIV_LAST) ? '0 : div_cnt_r + DIV_ONE);

   // Next-state and next-output logic for the IDLE/RUN sequencer.
   always_comb begin
      state_nxt_s       = state_r;
      h_nxt_s           = pixel_x_r;
      v_nxt_s           = pixel_y_r;
      h_phase_nxt_s     = h_phase_r;
      v_phase_nxt_s     = v_phase_r;
      pix_tick_nxt_s    = 1'b0;
      line_start_nxt_s  = 1'b0;
      frame_start_nxt_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (tick_s) begin
               state_nxt_s       = ST_RUN;
               h_nxt_s           = 10'd0;
               v_nxt_s           = 10'd0;
               h_phase_nxt_s     = PH_ACT;
               v_phase_nxt_s     = PH_ACT;
               pix_tick_nxt_s    = 1'b1;
               line_start_nxt_s  = 1'b1;
               frame_start_nxt_s = 1'b1;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (tick_s) begin
               pix_tick_nxt_s = 1'b1;
               if (pixel_x_r == H_LAST) begin
                  h_nxt_s          = 10'd0;
                  line_start_nxt_s = 1'b1;
                  if (pixel_y_r == V_LAST) begin
                     v_nxt_s           = 10'd0;
                     frame_start_nxt_s = 1'b1;
                  end else begin
                     v_nxt_s = pixel_y_r + 10'd1;
                  end
                  v_phase_nxt_s = phase_step(v_phase_r, v_nxt_s, V_B_FP, V_B_SYNC, V_B_BP);
               end else begin
                  h_nxt_s = pixel_x_r + 10'd1;
               end
               h_phase_nxt_s = phase_step(h_phase_r, h_nxt_s, H_B_FP, H_B_SYNC, H_B_BP);
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
      video_on_nxt_s = (state_nxt_s == ST_RUN) && (h_nxt_s < H_B_FP) && (v_nxt_s < V_B_FP);
      hsync_nxt_s    = ((state_nxt_s == ST_RUN) && (h_phase_nxt_s == PH_SYNC)) ? HS_POL : ~HS_POL;
      vsync_nxt_s    = ((state_nxt_s == ST_RUN) && (v_phase_nxt_s == PH_SYNC)) ? VS_POL : ~VS_POL;
   end

   // State, counters and all outputs share one edge so the outputs are zero-skew.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_r       <= ST_IDLE;
         div_cnt_r     <= '0;
         pixel_x_r     <= 10'd0;
         pixel_y_r     <= 10'd0;
         h_phase_r     <= PH_ACT;
         v_phase_r     <= PH_ACT;
         hsync_r       <= ~HS_POL;
         vsync_r       <= ~VS_POL;
         video_on_r    <= 1'b0;
         pix_tick_r    <= 1'b0;
         line_start_r  <= 1'b0;
         frame_start_r <= 1'b0;
      end else begin
         state_r       <= state_nxt_s;
         div_cnt_r     <= div_nxt_s;
         pixel_x_r     <= h_nxt_s;
         pixel_y_r     <= v_nxt_s;
         h_phase_r     <= h_phase_nxt_s;
         v_phase_r     <= v_phase_nxt_s;
         hsync_r       <= hsync_nxt_s;
         vsync_r       <= vsync_nxt_s;
         video_on_r    <= video_on_nxt_s;
         pix_tick_r    <= pix_tick_nxt_s;
         line_start_r  <= line_start_nxt_s;
         frame_start_r <= frame_start_nxt_s;
      end
   end

`ifdef VGA_FRAME_CNT_EN
   logic [15:0] frame_cnt_r;

   // Counts every frame start, including the first one out of IDLE.
   always_ff @(posedge clk) begin
      if (clr) begin
         frame_cnt_r <= 16'd0;
      end else begin
         frame_cnt_r <= frame_start_nxt_s ? frame_cnt_r + 16'd1 : frame_cnt_r;
      end
   end

   assign vga.frame_cnt = frame_cnt_r;
`endif

   assign vga.pix_tick    = pix_tick_r;
   assign vga.hsync       = hsync_r;
   assign vga.vsync       = vsync_r;
   assign vga.video_on    = video_on_r;
   assign vga.pixel_x     = pixel_x_r;
   assign vga.pixel_y     = pixel_y_r;
   assign vga.line_start  = line_start_r;
   assign vga.frame_start = frame_start_r;

endmodule
